if_stage: RTL and testbench

//  Instruction-fetch stage for the 5-stage pipelined LoongArch32 core; feeds the decode (ID) stage.

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_inst_buf.sv | 26 ++
 rtl/if_stage.sv | 81 ++++++++
 tb/tb_if_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared IF-stage definitions: reset PC, inter-stage bus widths and the
// IF->ID bus field layout that id_stage unpacks with the same offsets.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC        = 32'h1bff_fffc;
  localparam int          FS_TO_DS_BUS_WD = 65;
  localparam int          BR_BUS_WD       = 33;

  // IF->ID bus layout: {adef, pc[31:0], inst[31:0]}
  localparam int FS_BUS_ADEF_BIT = 64;
  localparam int FS_BUS_PC_LSB   = 32;
  localparam int FS_BUS_INST_LSB = 0;

  function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_fs_bus(
    input logic        adef,
    input logic [31:0] pc,
    input logic [31:0] inst
  );
    return {adef, pc, inst};
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// One-entry holding register for the fetched word while ID stalls; when
// empty it passes the SRAM read data straight through.
module if_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic        valid,
  output logic [31:0] inst
);

  logic [31:0] data;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= rdata;
    end
  end

  assign inst = valid ? data : rdata;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: nextpc generation, inst SRAM request, branch
// redirect from ID and a stall buffer holding the fetched word for ID.
//
// Handshake: ID takes {adef, pc, inst} on a cycle where fs_to_ds_valid and
// id_allowin are both 1; while id_allowin is 0 the bus is held unchanged.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_allowin,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic                       inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  logic        fs_valid;
  logic        fs_adef;
  logic [31:0] fs_pc;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic [31:0] buf_inst_out;
  logic        buf_valid;
  logic        buf_capture;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        to_fs_valid;
  logic        nextpc_misaligned;

  assign seq_pc            = fs_pc + 32'd4;
  assign nextpc            = br_taken ? br_target : seq_pc;
  assign nextpc_misaligned = (nextpc[1:0] != 2'b00);

  assign fs_ready_go = 1'b1;
  // A redirect frees IF even when ID is stalled: the held word is wrong-path.
  assign fs_allowin  = ~fs_valid | id_allowin | br_taken;
  assign to_fs_valid = ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC;
      fs_adef  <= 1'b0;
    end else if (to_fs_valid && fs_allowin) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
      fs_adef  <= nextpc_misaligned;
    end
  end

  // The SRAM drops its output after one cycle, so grab it before ID resumes.
  assign buf_capture = fs_valid & ~fs_adef & ~id_allowin & ~br_taken & ~buf_valid;

  if_inst_buf u_inst_buf (
    .clk     (clk),
    .reset   (reset),
    .capture (buf_capture),
    .clear   (fs_allowin),
    .rdata   (inst_sram_rdata),
    .valid   (buf_valid),
    .inst    (buf_inst_out)
  );

  assign fs_inst = fs_adef ? 32'h0 : buf_inst_out;

  assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken;
  assign fs_to_ds_bus   = pack_fs_bus(fs_adef, fs_pc, fs_inst);

  assign inst_sram_en    = to_fs_valid & fs_allowin & ~nextpc_misaligned;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a PC-level model predicts every output each
// cycle (inst is always the memory word at the held pc), plus literal checks.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int n_vec  = 0;
  int n_miss = 0;
  logic check_en = 1'b0;

  // model state: what IF is holding for ID
  logic        m_valid = 1'b0;
  logic        m_adef  = 1'b0;
  logic [31:0] m_pc    = 32'h1bff_fffc;

  logic [31:0] acc_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .id_allowin      (id_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c00_0008) return 32'h0280_0421;
    return a ^ 32'h8bad_f00d;
  endfunction

  // SRAM: one-cycle read; output is garbage after a cycle without a read
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : $urandom;

  function automatic logic [31:0] model_addr();
    return br_taken ? br_target : m_pc + 32'd4;
  endfunction

  always @(posedge clk) begin : model_update
    logic [31:0] a;
    a = model_addr();
    if (reset) begin
      m_valid = 1'b0;
      m_pc    = 32'h1bff_fffc;
      m_adef  = 1'b0;
    end else if (!m_valid || id_allowin || br_taken) begin
      m_valid = 1'b1;
      m_pc    = a;
      m_adef  = (a[1:0] != 2'b00);
    end
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [31:0] a;
    logic        exp_en;
    if (check_en) begin
      a      = model_addr();
      exp_en = !reset && (!m_valid || id_allowin || br_taken) && (a[1:0] == 2'b00);
      check("sram_we", inst_sram_we, 65'd0);
      check("sram_wdata", inst_sram_wdata, 65'd0);
      check("sram_addr", inst_sram_addr, a);
      check("sram_en", inst_sram_en, exp_en);
      check("to_ds_valid", fs_to_ds_valid, m_valid && !br_taken);
      if (m_valid && !br_taken)
        check("to_ds_bus", fs_to_ds_bus, {m_adef, m_pc, (m_adef ? 32'h0 : mem_word(m_pc))});
      if (fs_to_ds_valid && id_allowin) acc_q.push_back(fs_to_ds_bus[63:32]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic al, input logic br, input logic [31:0] tg);
    @(posedge clk);
    #1;
    id_allowin = al;
    br_taken   = br;
    br_target  = tg;
    @(negedge clk);
  endtask

  function automatic int count_acc(input logic [31:0] pc);
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i] == pc) n++;
    return n;
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; id_allowin = 1'b1; br_taken = 1'b0; br_target = 32'h0;
    @(posedge clk); #1; check_en = 1'b1;
    @(negedge clk);
    check("rst_valid", fs_to_ds_valid, 65'd0);
    check("rst_en", inst_sram_en, 65'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("first_addr", inst_sram_addr, 32'h1c00_0000);
    check("first_en", inst_sram_en, 65'd1);
    check("first_valid", fs_to_ds_valid, 65'd0);
    step(1, 0, 0);
    check("pc0_bus", fs_to_ds_bus, {1'b0, 32'h1c00_0000, 32'h97ad_f00d});
    check("pc0_addr", inst_sram_addr, 32'h1c00_0004);
    step(1, 0, 0);
    check("pc4_addr", inst_sram_addr, 32'h1c00_0008);
    // stall three cycles on 1c000008
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check("stall_bus", fs_to_ds_bus, {1'b0, 32'h1c00_0008, 32'h0280_0421});
      check("stall_en", inst_sram_en, 65'd0);
    end
    step(1, 0, 0);
    check("resume_bus", fs_to_ds_bus, {1'b0, 32'h1c00_0008, 32'h0280_0421});
    check("resume_addr", inst_sram_addr, 32'h1c00_000c);
    step(1, 0, 0);
    // redirect while IF holds 1c000010
    step(1, 1, 32'h1c00_0100);
    check("br_valid", fs_to_ds_valid, 65'd0);
    check("br_addr", inst_sram_addr, 32'h1c00_0100);
    step(0, 0, 0);
    check("tgt_valid", fs_to_ds_valid, 65'd1);
    check("tgt_pc", fs_to_ds_bus[63:32], 32'h1c00_0100);
    // redirect with ID stalled and buffer full
    step(0, 1, 32'h1c00_0200);
    check("br_stall_addr", inst_sram_addr, 32'h1c00_0200);
    step(0, 0, 0);
    check("br_stall_bus", fs_to_ds_bus, {1'b0, 32'h1c00_0200, 32'h97ad_f20d});
    // misaligned target
    step(1, 1, 32'h1c00_0102);
    check("adef_en", inst_sram_en, 65'd0);
    step(0, 0, 0);
    check("adef_bus", fs_to_ds_bus, {1'b1, 32'h1c00_0102, 32'h0});
    step(1, 0, 0);
    check("adef_seq_addr", inst_sram_addr, 32'h1c00_0106);
    step(1, 0, 0);
    check("adef_seq_bus", fs_to_ds_bus, {1'b1, 32'h1c00_0106, 32'h0});
    // pc wraps past 2^32
    step(1, 1, 32'hffff_fffc);
    step(1, 0, 0);
    check("wrap_addr", inst_sram_addr, 32'h0);
    step(1, 0, 0);
    check("wrap_bus", fs_to_ds_bus, {1'b0, 32'h0, 32'h8bad_f00d});
    // reset in the middle of a stall with the buffer full
    step(1, 1, 32'h1c00_0300);
    step(0, 0, 0);
    step(0, 0, 0);
    check("pre_rst_bus", fs_to_ds_bus, {1'b0, 32'h1c00_0300, 32'h97ad_f30d});
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_valid", fs_to_ds_valid, 65'd0);
    check("midrst_en", inst_sram_en, 65'd0);
    @(posedge clk); #1; reset = 1'b0; id_allowin = 1'b1;
    @(negedge clk);
    check("restart_addr", inst_sram_addr, 32'h1c00_0000);
    step(1, 0, 0);
    check("restart_bus", fs_to_ds_bus, {1'b0, 32'h1c00_0000, 32'h97ad_f00d});
    step(1, 0, 0);
    // ---------------- final report ----------------
    check("never_acc_1c000010", count_acc(32'h1c00_0010), 65'd0);
    check("never_acc_1c000100", count_acc(32'h1c00_0100), 65'd0);
    check("once_acc_1c000008", count_acc(32'h1c00_0008), 65'd1);
    check("once_acc_1c000102", count_acc(32'h1c00_0102), 65'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
